fft_usb_packetizer: RTL
=======================

# fft_usb_packetizer

Parametrised serializer between the FFT output stream and the FT245 USB byte interface. It buffers incoming FFT bins (bin index, real, imaginary, channel tag) in a small FIFO and emits each bin as a fixed-length, sync-tagged byte packet over a valid/ready byte stream.

Compared with the current fixed 8-byte packing, it adds:
- downstream backpressure;
- configurable widths and channel count;
- an optional XOR checksum byte;
- overflow accounting.

## Interface
Parameters:
- N_WIDTH, 10, bin-index width
- DATA_WIDTH, 25, width of each signed re/im sample
- CHAN_WIDTH, 2, channel-tag width (≥1)
- FIFO_DEPTH, 8, input FIFO entries (power of two, ≥2)
- CHECKSUM, 1, append XOR checksum byte when 1
- SYNC, 4'hF, 4-bit sync nibble leading every packet

Ports:
- clk_i  in  1  block clock; all logic on posedge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  one bin presented this cycle (no ready; source cannot stall)
- in_chan_i  in  CHAN_WIDTH  channel tag
- in_bin_i  in  N_WIDTH  bin index
- in_re_i  in  DATA_WIDTH  real part, signed
- in_im_i  in  DATA_WIDTH  imaginary part, signed
- out_valid_o  out  1  out_data_o holds a packet byte
- out_data_o  out  8  packet byte
- out_ready_i  in  1  sink accepts byte when high with out_valid_o
- out_last_o  out  1  marks final byte of packet
- clear_i  in  1  synchronous clear of drop_count_o and overflow_o
- overflow_o  out  1  sticky: at least one bin dropped
- drop_count_o  out  16  dropped-bin count, saturating at 16'hFFFF

## Operation
- Packet bit vector, sent MSB first: {SYNC, chan, bin, re, im, zero pad}.
- Payload bits P = 4+CHAN_WIDTH+N_WIDTH+2·DATA_WIDTH. PKT_BYTES = ceil(P/8); zero pad bits fill the LSB end.
- With defaults: P=66, giving 9 payload bytes and 6 pad bits; packet length is 10 bytes with CHECKSUM=1.
- Checksum byte: XOR of all payload bytes. It is sent last, and out_last_o moves to it.
- Input FIFO:
  - in_valid_i pushes when not full.
  - Push while full is accepted only if a pop occurs the same cycle. Otherwise the bin is dropped, overflow_o sets and drop_count_o increments (saturating).
- State machine:
  - IDLE: if FIFO non-empty, pop into the shift register and clear byte_ctr → SEND.
  - SEND: present the current byte. On out_valid_o & out_ready_i, advance the byte and XOR it into the checksum. After the final payload byte → CSUM if CHECKSUM, else packet done.
  - CSUM: present the checksum byte; on acceptance the packet is done.
  - On packet done: if the FIFO is non-empty, pop and reload in the same cycle and stay in SEND (no gap). Otherwise → IDLE.
- out_data_o and out_last_o are stable while out_valid_o=1 and out_ready_i=0.
- clear_i and a same-cycle drop: clear wins, but the counter reads 1 and overflow_o stays 1 on the following cycle.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, overflow_o=0, drop_count_o=0; FIFO empty; state IDLE. Reset mid-packet discards the partial packet and all FIFO contents.
- Latency: a push in cycle 0 into an empty, idle block gives out_valid_o=1 with the first byte in cycle 2.
- Throughput: one byte per cycle with out_ready_i held high; packets are back-to-back.
- Registered outputs only; no combinational path from out_ready_i to out_valid_o.

## Structure
- Shared package holds:
  - the packet-length function PKT_BYTES(N_WIDTH, CHAN_WIDTH, DATA_WIDTH);
  - the SYNC constant;
  - the state enumeration (IDLE, SEND, CSUM).
- One sub-module: sync_fifo (width CHAN_WIDTH+N_WIDTH+2·DATA_WIDTH, depth FIFO_DEPTH), providing full/empty and same-cycle push/pop.

## Test plan
- **Single packet:** defaults, one push of chan=1, bin=0x155, re=1, im=-1, with out_ready_i=1.
  - Required bytes: F5 55 00 00 00 FF FF FF C0 9F.
  - out_last_o high only on 9F; first byte appears 2 cycles after the push.
- **Backpressure:** same packet with out_ready_i toggling 1,0,0,1,… → identical byte sequence; bytes held stable during stalls.
- **Overflow:** FIFO_DEPTH=8 with out_ready_i=0, 12 consecutive pushes.
  - 8 bins are accepted. The first is popped into the shift register, freeing one slot, so 9 are held and 3 are dropped.
  - overflow_o=1, drop_count_o=3. clear_i then gives 0/0.
- **Back-to-back:** 4 pushes with out_ready_i=1 → 40 contiguous valid bytes, out_last_o on bytes 10/20/30/40.
- **CHECKSUM=0, DATA_WIDTH=16, N_WIDTH=8:** packet of ceil(46/8)=6 bytes; out_last_o on byte 6.
- **Reset mid-packet:** assert rst_i after byte 3 → all outputs 0 next cycle; a new push afterwards gives a complete, correct packet.

Source files
------------

// File: rtl/fft_usb_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_usb_packetizer_pkg
// Purpose  : Shared constants, state encoding and packet-length helper for
//            the FFT-to-USB byte packetizer.
// Revision : 1.0 - initial release
// ============================================================================
package fft_usb_packetizer_pkg;

    // Default sync nibble that leads every packet.
    localparam logic [3:0] c_SYNC = 4'hF;

    // Packetizer state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_SEND = 2'd1;
    localparam state_t c_ST_CSUM = 2'd2;

    // Number of payload bytes (sync + chan + bin + re + im, rounded up).
    function automatic int PKT_BYTES(input int n_w, input int chan_w, input int data_w);
        return (4 + chan_w + n_w + 2 * data_w + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_usb_packetizer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fft_usb_packetizer_sync_fifo
// Purpose  : Single-clock FIFO with first-word fall-through read data.
//            A push and a pop in the same cycle are both honoured, also
//            when the FIFO is full (the popped slot is the one written).
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            i_push/i_data - write strobe and data
//            i_pop/o_data  - read strobe and head-of-queue data
//            o_full/o_empty- occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module fft_usb_packetizer_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/fft_usb_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : fft_usb_packetizer
// Purpose  : Buffers FFT bins and serialises each one as a sync-tagged,
//            fixed-length byte packet on a valid/ready byte stream, with an
//            optional trailing XOR checksum and dropped-bin accounting.
// Ports    : clk_i, rst_i              - clock, async active-high reset
//            in_valid_i, in_chan_i,
//            in_bin_i, in_re_i, in_im_i - FFT bin input (cannot stall)
//            out_valid_o, out_data_o,
//            out_ready_i, out_last_o    - byte stream output
//            clear_i                    - clears overflow_o / drop_count_o
//            overflow_o, drop_count_o   - sticky drop flag, saturating count
// Revision : 1.0 - initial release
// ============================================================================
module fft_usb_packetizer
    import fft_usb_packetizer_pkg::*;
#(
    parameter int         N_WIDTH    = 10,
    parameter int         DATA_WIDTH = 25,
    parameter int         CHAN_WIDTH = 2,
    parameter int         FIFO_DEPTH = 8,
    parameter int         CHECKSUM   = 1,
    parameter logic [3:0] SYNC       = c_SYNC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [CHAN_WIDTH-1:0] in_chan_i,
    input  logic [N_WIDTH-1:0]    in_bin_i,
    input  logic [DATA_WIDTH-1:0] in_re_i,
    input  logic [DATA_WIDTH-1:0] in_im_i,
    output logic                  out_valid_o,
    output logic [7:0]            out_data_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    input  logic                  clear_i,
    output logic                  overflow_o,
    output logic [15:0]           drop_count_o
);

    localparam int c_ENTRY_W   = CHAN_WIDTH + N_WIDTH + 2 * DATA_WIDTH;
    localparam int c_PAY_BYTES = PKT_BYTES(N_WIDTH, CHAN_WIDTH, DATA_WIDTH);
    localparam int c_VEC_W     = 8 * c_PAY_BYTES;
    localparam int c_PAD_W     = c_VEC_W - 4 - c_ENTRY_W;
    localparam int c_CTR_W     = $clog2(c_PAY_BYTES + 1);

    typedef logic [c_VEC_W-1:0] vec_t;
    localparam logic [c_CTR_W-1:0] c_LAST_IDX = c_CTR_W'(c_PAY_BYTES - 1);

    // FIFO interface
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [c_ENTRY_W-1:0] w_fifo_dout;
    vec_t                 w_vec;

    // Registered state
    state_t               r_state;
    vec_t                 r_shift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_last;
    logic [c_CTR_W-1:0]   r_ctr;
    logic [7:0]           r_csum;
    logic                 r_overflow;
    logic [15:0]          r_drop_cnt;

    // Next-state values
    state_t               w_state_nxt;
    vec_t                 w_shift_nxt;
    logic [7:0]           w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_last_nxt;
    logic [c_CTR_W-1:0]   w_ctr_nxt;
    logic [7:0]           w_csum_nxt;
    logic                 w_accept;
    logic                 w_done;
    logic [7:0]           w_csum_acc;
    logic [c_CTR_W-1:0]   w_ctr_inc;

    // A full FIFO still takes a bin if the head leaves in the same cycle.
    assign w_push = in_valid_i & (~w_full | w_pop);
    assign w_drop = in_valid_i & w_full & ~w_pop;

    fft_usb_packetizer_sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  ({in_chan_i, in_bin_i, in_re_i, in_im_i}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Packet image, MSB first, zero pad at the LSB end.
    assign w_vec      = vec_t'({SYNC, w_fifo_dout}) << c_PAD_W;
    assign w_accept   = r_valid & out_ready_i;
    assign w_csum_acc = r_csum ^ r_data;
    assign w_ctr_inc  = r_ctr + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_ctr_nxt   = r_ctr;
        w_csum_nxt  = r_csum;
        w_pop       = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) w_pop = 1'b1;
            end
            c_ST_SEND: begin
                if (w_accept) begin
                    w_csum_nxt = w_csum_acc;
                    if (r_ctr == c_LAST_IDX) begin
                        if (CHECKSUM != 0) begin
                            w_state_nxt = c_ST_CSUM;
                            w_data_nxt  = w_csum_acc;
                            w_last_nxt  = 1'b1;
                        end else begin
                            w_done = 1'b1;
                        end
                    end else begin
                        w_data_nxt  = r_shift[c_VEC_W-1 -: 8];
                        w_shift_nxt = r_shift << 8;
                        w_ctr_nxt   = w_ctr_inc;
                        w_last_nxt  = (CHECKSUM == 0) && (w_ctr_inc == c_LAST_IDX);
                    end
                end
            end
            c_ST_CSUM: begin
                if (w_accept) w_done = 1'b1;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_data_nxt  = 8'h00;
            end
        endcase

        // Chain straight into the next packet when one is waiting.
        if (w_done) begin
            if (!w_empty) begin
                w_pop = 1'b1;
            end else begin
                w_state_nxt = c_ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_data_nxt  = 8'h00;
            end
        end

        if (w_pop) begin
            w_state_nxt = c_ST_SEND;
            w_data_nxt  = w_vec[c_VEC_W-1 -: 8];
            w_shift_nxt = w_vec << 8;
            w_ctr_nxt   = '0;
            w_csum_nxt  = 8'h00;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (CHECKSUM == 0) && (c_PAY_BYTES == 1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_shift <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ctr   <= '0;
            r_csum  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_ctr   <= w_ctr_nxt;
            r_csum  <= w_csum_nxt;
        end
    end

    // A drop coinciding with clear is kept as the first event after the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else if (clear_i) begin
            r_overflow <= w_drop;
            r_drop_cnt <= w_drop ? 16'h0001 : 16'h0000;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'h0001;
        end
    end

    assign out_valid_o  = r_valid;
    assign out_data_o   = r_data;
    assign out_last_o   = r_last;
    assign overflow_o   = r_overflow;
    assign drop_count_o = r_drop_cnt;

endmodule
`default_nettype wire
